// File: rtl/bit_demux_rx.sv
// bit_demux_rx
//   Demultiplexes a 2:1 time-interleaved serial stream back into two
//   WIDTH-bit channel words. Slot 0 (the cycle of frame_start) carries
//   ch0 bit 0 and slot 1 carries ch1 bit 0. Bits arrive LSB first and the
//   channels alternate every cycle. A completed frame is held on out0/out1
//   with out_valid until the consumer accepts it with out_ready. If a frame
//   completes while an unaccepted frame is still held, the new frame is
//   dropped and the sticky overrun flag is set.
//
//   Optional feature: define PARITY_CHECK_EN to add two trailing slots per
//   frame. Slot 2*WIDTH carries the ch0 even-parity bit and slot
//   2*WIDTH+1 carries the ch1 even-parity bit. parity_err then reports the
//   parity result of each loaded frame.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   din          interleaved serial input
//   frame_start  pulse coincident with slot 0 of a frame
//   out_ready    consumer accepts the held frame
//   overrun_clr  clears the sticky overrun flag
//   out0/out1    reconstructed ch0/ch1 words
//   out_valid    out0/out1 hold an unaccepted frame
//   sel_cur      channel of the current slot (0 when idle)
//   busy         frame reception in progress
//   overrun      sticky; a completed frame was dropped
//   parity_err   (PARITY_CHECK_EN only) parity failure of the held frame
module bit_demux_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             out_valid,
  output logic             sel_cur,
  output logic             busy,
  output logic             overrun
`ifdef PARITY_CHECK_EN
  ,
  output logic             parity_err
`endif
);

`ifdef PARITY_CHECK_EN
  localparam int SLOTS = 2 * WIDTH + 2;
`else
  localparam int SLOTS = 2 * WIDTH;
`endif
  localparam int KW = $clog2(SLOTS);
  localparam logic [KW-1:0] LAST = KW'(SLOTS - 1);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_cur_q, sel_cur_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
`ifdef PARITY_CHECK_EN
  logic             p0_q, p0_d;
  logic             parity_err_q, parity_err_d;
  logic             perr_calc;
`endif

  logic             slot_en;
  logic [KW-1:0]    cur_k;
  logic             complete;
  logic             load;
  logic [WIDTH-1:0] fin0;
  logic [WIDTH-1:0] fin1;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    complete    = 1'b0;
`ifdef PARITY_CHECK_EN
    p0_d         = p0_q;
    parity_err_d = parity_err_q;
`endif

    // frame_start always restarts at slot 0, aborting any partial frame
    slot_en = frame_start || (state_q == S_RECV);
    cur_k   = frame_start ? '0 : k_q;

    if (slot_en) begin
`ifdef PARITY_CHECK_EN
      if (cur_k < KW'(2 * WIDTH)) begin
`else
      begin
`endif
        // Shift in at the MSB so that after WIDTH shifts the LSB-first
        // stream lands in natural bit order.
        if (!cur_k[0]) sh0_d = {din, sh0_q[WIDTH-1:1]};
        else           sh1_d = {din, sh1_q[WIDTH-1:1]};
      end
`ifdef PARITY_CHECK_EN
      else if (!cur_k[0]) begin
        p0_d = din;
      end
`endif
      if (cur_k == LAST) begin
        complete = 1'b1;
        state_d  = S_IDLE;
        k_d      = '0;
      end else begin
        state_d  = S_RECV;
        k_d      = cur_k + KW'(1);
      end
    end

`ifdef PARITY_CHECK_EN
    // Last slot is the ch1 parity bit, so the data words are already complete
    fin0      = sh0_q;
    fin1      = sh1_q;
    perr_calc = (^sh0_q ^ p0_q) | (^sh1_q ^ din);
`else
    // Last slot is ch1 bit WIDTH-1, so take the shifted value
    fin0      = sh0_d;
    fin1      = sh1_d;
`endif

    load = complete && (!out_valid_q || out_ready);

    if (load) begin
      out0_d      = fin0;
      out1_d      = fin1;
      out_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
      parity_err_d = perr_calc;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Setting the flag takes priority over clearing it
    if (complete && !load)  overrun_d = 1'b1;
    else if (overrun_clr)   overrun_d = 1'b0;

    busy_d    = (state_d == S_RECV);
    sel_cur_d = (state_d == S_RECV) ? k_d[0] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      out_valid_q <= 1'b0;
      sel_cur_q   <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      p0_q         <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out_valid_q <= out_valid_d;
      sel_cur_q   <= sel_cur_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
`ifdef PARITY_CHECK_EN
      p0_q         <= p0_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out_valid = out_valid_q;
  assign sel_cur   = sel_cur_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/bit_demux_rx.md
BIT_DEMUX_RX -- requirements
Module: bit_demux_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-002 Parameter WIDTH, default 8, SHALL set the bits per channel per frame (WIDTH >= 2).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 din  input  1  serial stream from a 2:1 mux whose select toggles every cycle (even slot = ch0, odd slot = ch1).
REQ-006 frame_start  input  1  single-cycle pulse, coincident with ch0 bit 0 of a frame.
REQ-007 out_ready  input  1  consumer accepts the held frame.
REQ-008 overrun_clr  input  1  clears the sticky overrun flag.
REQ-009 out0  output  WIDTH  reconstructed ch0 word.
REQ-010 out1  output  WIDTH  reconstructed ch1 word.
REQ-011 out_valid  output  1  out0/out1 hold a complete, unaccepted frame.
REQ-012 sel_cur  output  1  channel of the current slot (0 = ch0, 1 = ch1); 0 when idle.
REQ-013 busy  output  1  a frame is being received.
REQ-014 overrun  output  1  sticky; a completed frame was dropped.
REQ-015 parity_err  output  1  present only when PARITY_CHECK_EN is defined (see Configuration).

Function
REQ-016 States SHALL be IDLE and RECV; IDLE->RECV on frame_start; RECV->IDLE after the last slot.
REQ-017 Slot counter k SHALL run 0..2*WIDTH-1 (plus 2 with parity); din at the cycle of frame_start is slot 0.
REQ-018 Even slot k SHALL capture din into ch0 shift bit k/2; odd slot into ch1 bit (k-1)/2; LSB first.
REQ-019 Capture SHALL use internal shift registers; out0/out1 SHALL change only on frame completion.
REQ-020 out_valid SHALL rise the cycle after the last slot (latency 1) with out0/out1 updated that edge.
REQ-021 out_valid SHALL fall the cycle after out_valid & out_ready; out0/out1 keep their value.
REQ-022 If a frame completes while out_valid=1 and out_ready=0, the new frame SHALL be dropped, old data kept, and overrun set.
REQ-023 If completion coincides with out_valid & out_ready, the new frame SHALL load, out_valid stays 1, no overrun.
REQ-024 frame_start during RECV SHALL abort the partial frame and restart at slot 0 with the current din; nothing is output.
REQ-025 frame_start in the cycle after the last slot SHALL start a new frame (back-to-back, no gap).
REQ-026 overrun SHALL clear on overrun_clr; if set and clear coincide, set wins.
REQ-027 busy SHALL be 1 exactly in RECV; sel_cur SHALL equal k[0] in RECV.

Reset
REQ-028 rst SHALL immediately force IDLE, k=0, out0=out1=0, out_valid=0, busy=0, sel_cur=0, overrun=0, parity_err=0.
REQ-029 rst during RECV SHALL discard the partial frame; reception resumes only on a later frame_start.

Configuration
REQ-030 Macro PARITY_CHECK_EN: when defined, each frame SHALL carry two extra slots (2*WIDTH = ch0 even parity, 2*WIDTH+1 = ch1 even parity).
REQ-031 With PARITY_CHECK_EN, parity_err SHALL update with out_valid on each loaded frame: 1 if either channel fails even parity, else 0; data is delivered regardless.
REQ-032 Without PARITY_CHECK_EN, frames SHALL be 2*WIDTH slots and the parity_err port SHALL not exist.

Verification
REQ-033 WIDTH=8, no parity: send ch0=0xA5, ch1=0x3C interleaved LSB first, out_ready=1 -> out_valid for 1 cycle at slot 16, out0=0xA5, out1=0x3C.
REQ-034 Two back-to-back frames (0x01/0x80, then 0xFF/0x00), out_ready=0 -> first frame held, second dropped, overrun=1; overrun_clr -> overrun=0.
REQ-035 frame_start re-pulsed at slot 7, then full frame 0x55/0xAA -> single out_valid, out0=0x55, out1=0xAA.
REQ-036 rst asserted at slot 9 mid-frame -> all outputs 0 immediately; no out_valid until a new frame completes.
REQ-037 PARITY_CHECK_EN, 0x07/0x03 with parity bits 1/0 -> parity_err=0; ch0 parity bit flipped to 0 -> parity_err=1, out0=0x07.
REQ-038 Completion in the same cycle as accept of the prior frame -> out_valid stays 1, new data loaded, overrun=0.
